u3v_payload_chunk_gen: RTL and testbench
========================================

U3V_PAYLOAD_CHUNK_GEN -- requirements
Module: u3v_payload_chunk_gen

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, data path width; must equal REG_WD.
REQ-002 SHALL have parameter REG_WD, default 32, register width.
REQ-003 SHALL have parameter LONG_REG_WD, default 64, width of each chunk value.
REQ-004 SHALL have parameter CHUNK_NUM, default 4, range 1..8, number of optional 64-bit chunk entries.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 i_image_flag, i_chunk_flag, i_data_valid  input  1 each  image window, chunk window, image word valid.
REQ-008 iv_data  input  DATA_WD  image word.
REQ-009 i_chunk_mode_active  input  1  chunk master enable.
REQ-010 iv_chunk_en  input  CHUNK_NUM  per-entry enable.
REQ-011 iv_chunk_value  input  CHUNK_NUM*LONG_REG_WD  entry k value is bits [k*64 +: 64].
REQ-012 iv_chunk_size_img, i_stream_enable  input  REG_WD / 1  configured image byte size; stream enable.
REQ-013 o_data_valid, ov_data  output  1 / DATA_WD  payload+chunk word stream.
REQ-014 ov_valid_payload_size  output  REG_WD; ov_status  output  16; o_chunk_done  output  1, one-cycle pulse.

Function
REQ-015 SHALL latch i_chunk_mode_active and iv_chunk_en only on the cycle after the i_stream_enable rising edge; the latched copies are used everywhere else.
REQ-016 SHALL forward image words registered: i_image_flag&i_data_valid -> o_data_valid=1 and ov_data=iv_data one cycle later.
REQ-017 SHALL snapshot iv_chunk_value and iv_chunk_size_img on the i_chunk_flag rising edge.
REQ-018 SHALL use FSM states IDLE, IMG, ENT, DONE.
REQ-019 IDLE->IMG on the i_chunk_flag rising edge when latched mode=1; when mode=0, SHALL stay in IDLE and emit nothing.
REQ-020 IMG SHALL emit 2 words: 32'h1, then the size snapshot.
REQ-021 ENT SHALL emit 4 words per enabled entry k, in ascending k: value[31:0], value[63:32], id=k+2, length=32'h8.
REQ-022 Disabled entries SHALL be skipped with zero idle cycles between emitted words.
REQ-023 After the last word, the FSM SHALL enter DONE, pulse o_chunk_done for 1 cycle, then return to IDLE.
REQ-024 Any cycle with i_image_flag&i_data_valid SHALL output the image word; the FSM holds that cycle without advancing.
REQ-025 i_chunk_flag falling before the sequence completes SHALL abort to IDLE with no o_chunk_done.
REQ-026 SHALL count image words during i_image_flag, clearing on its rising edge; on its falling edge act_bytes = count<<2.
REQ-027 ov_status SHALL be 16'hA101 when act_bytes > iv_chunk_size_img, else 16'h0000.
REQ-028 ov_valid_payload_size SHALL equal min(act_bytes, iv_chunk_size_img) + (mode ? 8+16*popcount(latched en) : 0), registered, with REG_WD wrap-around.
REQ-029 o_data_valid=0 SHALL force ov_data=0.

Reset
REQ-030 reset SHALL asynchronously clear all outputs, the FSM (to IDLE), counters, snapshots and latched configuration to 0.
REQ-031 reset asserted mid-sequence SHALL truncate output immediately; after release, nothing is emitted until a new i_chunk_flag rising edge.

Structure
REQ-032 SHALL place in shared package u3v_pkg: FSM state encoding, IMG chunk ID 32'h1, entry length 32'h8, entry ID base 2, and status code 16'hA101.
REQ-033 SHALL instantiate one sub-module u3v_chunk_sel that returns the next enabled entry index at or after a given index, plus a none-left flag.

Verification
REQ-034 Mode=1, en=4'b0101, chunk_flag high 12 cycles, size=0x100 -> words 1, 0x100, v0lo, v0hi, 2, 8, v2lo, v2hi, 4, 8 back-to-back, then o_chunk_done.
REQ-035 64 image words, size=0x80 -> ov_status=A101; with mode=1 and en=0101, ov_valid_payload_size=0x80+40=0xA8.
REQ-036 Mode toggled while i_stream_enable stays high -> no change in chunk output until the next stream-enable rise.
REQ-037 i_chunk_flag dropped after the 3rd word -> output stops, no o_chunk_done.
REQ-038 reset pulsed during ENT -> all outputs 0 in the same cycle; the FSM stays in IDLE after release.
REQ-039 Mode=0 -> image words only; ov_valid_payload_size = min(act_bytes, size).

Source files
------------

// File: rtl/u3v_pkg.sv
// rtl/u3v_pkg.sv - shared constants and FSM encoding for the U3V payload chunk generator
//
// Purpose: state encoding for the chunk sequencer plus the fixed chunk
// field values (IMG chunk ID, entry ID base, entry length, oversize status).
// Ports: none (package).
package u3v_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IMG  = 2'd1,
    ST_ENT  = 2'd2,
    ST_DONE = 2'd3
  } chunk_state_t;

  localparam logic [31:0] IMG_CHUNK_ID    = 32'h0000_0001;
  localparam logic [31:0] ENT_CHUNK_LEN   = 32'h0000_0008;
  localparam logic [31:0] ENT_ID_BASE     = 32'd2;
  localparam logic [15:0] STATUS_OVERSIZE = 16'hA101;

endpackage

// File: rtl/u3v_chunk_sel.sv
// rtl/u3v_chunk_sel.sv - finds the next enabled chunk entry at or after a start index
//
// Purpose: priority search over the latched entry-enable mask.
// Ports:
//   en    - per-entry enable mask
//   start - first index eligible for selection
//   idx   - lowest enabled index >= start (0 when none)
//   none  - no enabled entry remains at or after start
module u3v_chunk_sel #(
  parameter int CHUNK_NUM = 4,
  parameter int IDX_WD    = 4
) (
  input  logic [CHUNK_NUM-1:0] en,
  input  logic [IDX_WD-1:0]    start,
  output logic [IDX_WD-1:0]    idx,
  output logic                 none
);

  // Scan downward so the lowest qualifying index is the one left standing.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int k = CHUNK_NUM - 1; k >= 0; k--) begin
      if (en[k] && (IDX_WD'(k) >= start)) begin
        idx  = IDX_WD'(k);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/u3v_payload_chunk_gen.sv
// rtl/u3v_payload_chunk_gen.sv - forwards image words and appends U3V chunk words after the image
//
// Purpose: registered image-word pass-through, chunk sequence (IMG chunk
// header then 4 words per enabled entry), image byte accounting, status and
// valid-payload-size reporting.
// Ports:
//   clk, reset                        - clock, async active-high reset
//   i_image_flag/i_data_valid/iv_data - image window, word valid, word
//   i_chunk_flag                      - chunk window; its rise starts a sequence
//   i_chunk_mode_active, iv_chunk_en  - chunk config, latched after stream-enable rise
//   iv_chunk_value                    - entry k value at [k*LONG_REG_WD +: LONG_REG_WD]
//   iv_chunk_size_img                 - configured image byte size
//   i_stream_enable                   - stream enable
//   o_data_valid/ov_data              - output word stream
//   ov_valid_payload_size, ov_status  - payload size and oversize status
//   o_chunk_done                      - one-cycle pulse after the last chunk word
module u3v_payload_chunk_gen
  import u3v_pkg::*;
#(
  parameter int DATA_WD     = 32,
  parameter int REG_WD      = 32,
  parameter int LONG_REG_WD = 64,
  parameter int CHUNK_NUM   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_image_flag,
  input  logic                           i_chunk_flag,
  input  logic                           i_data_valid,
  input  logic [DATA_WD-1:0]             iv_data,
  input  logic                           i_chunk_mode_active,
  input  logic [CHUNK_NUM-1:0]           iv_chunk_en,
  input  logic [CHUNK_NUM*LONG_REG_WD-1:0] iv_chunk_value,
  input  logic [REG_WD-1:0]              iv_chunk_size_img,
  input  logic                           i_stream_enable,
  output logic                           o_data_valid,
  output logic [DATA_WD-1:0]             ov_data,
  output logic [REG_WD-1:0]              ov_valid_payload_size,
  output logic [15:0]                    ov_status,
  output logic                           o_chunk_done
);

  localparam int IDX_WD = 4;

  // Edge detectors keep the inverted previous level so that every register
  // resets to 0 and a level held high across reset is not seen as a rise.
  logic se_low_d, latch_pulse, cf_low_d, img_low_d, img_d;
  logic mode_l;
  logic [CHUNK_NUM-1:0] en_l;
  logic [CHUNK_NUM*LONG_REG_WD-1:0] value_snap;
  logic [REG_WD-1:0] size_snap, img_cnt, act_bytes;

  logic img_word, cf_rise, img_rise, img_fall, se_rise;
  assign img_word = i_image_flag & i_data_valid;
  assign cf_rise  = i_chunk_flag & cf_low_d;
  assign img_rise = i_image_flag & img_low_d;
  assign img_fall = img_d & ~i_image_flag;
  assign se_rise  = i_stream_enable & se_low_d;

  chunk_state_t state, state_nxt;
  logic [IDX_WD-1:0] idx, idx_nxt, sel_start, sel_idx;
  logic [1:0] sub, sub_nxt;
  logic sel_none, emit_v;
  logic [DATA_WD-1:0] emit_d;
  logic [LONG_REG_WD-1:0] cur_val;

  u3v_chunk_sel #(.CHUNK_NUM(CHUNK_NUM), .IDX_WD(IDX_WD)) u_sel (
    .en    (en_l),
    .start (sel_start),
    .idx   (sel_idx),
    .none  (sel_none)
  );

  assign cur_val = value_snap[int'(idx)*LONG_REG_WD +: LONG_REG_WD];

  // Next-state and chunk word selection. An image word in the same cycle
  // takes the output slot, so the sequencer holds instead of emitting.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sub_nxt   = sub;
    emit_v    = 1'b0;
    emit_d    = '0;
    sel_start = '0;
    case (state)
      ST_IDLE: begin
        sub_nxt = 2'd0;
        if (cf_rise && mode_l) state_nxt = ST_IMG;
      end
      ST_IMG: begin
        if (!i_chunk_flag) begin
          state_nxt = ST_IDLE;
        end else if (!img_word) begin
          emit_v = 1'b1;
          emit_d = sub[0] ? DATA_WD'(size_snap) : DATA_WD'(IMG_CHUNK_ID);
          if (!sub[0]) begin
            sub_nxt = 2'd1;
          end else begin
            sub_nxt = 2'd0;
            if (sel_none) begin
              state_nxt = ST_DONE;
            end else begin
              state_nxt = ST_ENT;
              idx_nxt   = sel_idx;
            end
          end
        end
      end
      ST_ENT: begin
        sel_start = idx + IDX_WD'(1);
        if (!i_chunk_flag) begin
          state_nxt = ST_IDLE;
        end else if (!img_word) begin
          emit_v  = 1'b1;
          sub_nxt = sub + 2'd1;
          case (sub)
            2'd0:    emit_d = cur_val[DATA_WD-1:0];
            2'd1:    emit_d = cur_val[LONG_REG_WD-1 -: DATA_WD];
            2'd2:    emit_d = DATA_WD'(ENT_ID_BASE) + DATA_WD'(idx);
            default: emit_d = DATA_WD'(ENT_CHUNK_LEN);
          endcase
          if (sub == 2'd3) begin
            if (sel_none) state_nxt = ST_DONE;
            else          idx_nxt   = sel_idx;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      sub   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      sub   <= sub_nxt;
    end
  end

  // Configuration latch, snapshots and edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      se_low_d    <= 1'b0;
      latch_pulse <= 1'b0;
      cf_low_d    <= 1'b0;
      img_low_d   <= 1'b0;
      img_d       <= 1'b0;
      mode_l      <= 1'b0;
      en_l        <= '0;
      value_snap  <= '0;
      size_snap   <= '0;
      img_cnt     <= '0;
      act_bytes   <= '0;
    end else begin
      se_low_d    <= ~i_stream_enable;
      latch_pulse <= se_rise;
      cf_low_d    <= ~i_chunk_flag;
      img_low_d   <= ~i_image_flag;
      img_d       <= i_image_flag;
      if (latch_pulse) begin
        mode_l <= i_chunk_mode_active;
        en_l   <= iv_chunk_en;
      end
      if (cf_rise) begin
        value_snap <= iv_chunk_value;
        size_snap  <= iv_chunk_size_img;
      end
      if (img_rise)      img_cnt <= img_word ? REG_WD'(1) : '0;
      else if (img_word) img_cnt <= img_cnt + REG_WD'(1);
      if (img_fall) act_bytes <= img_cnt << 2;
    end
  end

  logic [REG_WD-1:0] pop, min_bytes, extra;
  always_comb begin
    pop = '0;
    for (int k = 0; k < CHUNK_NUM; k++) pop = pop + REG_WD'(en_l[k]);
    min_bytes = (act_bytes > iv_chunk_size_img) ? iv_chunk_size_img : act_bytes;
    // IMG chunk trailer is 8 bytes; each entry adds 8 data + 8 trailer bytes.
    extra = mode_l ? (REG_WD'(8) + (pop << 4)) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_data_valid          <= 1'b0;
      ov_data               <= '0;
      o_chunk_done          <= 1'b0;
      ov_status             <= '0;
      ov_valid_payload_size <= '0;
    end else begin
      o_data_valid          <= img_word | emit_v;
      ov_data               <= img_word ? iv_data : (emit_v ? emit_d : '0);
      o_chunk_done          <= (state == ST_DONE);
      ov_status             <= (act_bytes > iv_chunk_size_img) ? STATUS_OVERSIZE : 16'h0000;
      ov_valid_payload_size <= min_bytes + extra;
    end
  end

endmodule

// File: tb/tb_u3v_payload_chunk_gen.sv
// tb/tb_u3v_payload_chunk_gen.sv - directed self-checking bench for u3v_payload_chunk_gen
module tb_u3v_payload_chunk_gen;

  logic clk = 1'b0;
  logic reset;
  logic i_image_flag, i_chunk_flag, i_data_valid;
  logic [31:0] iv_data;
  logic i_chunk_mode_active;
  logic [3:0] iv_chunk_en;
  logic [255:0] iv_chunk_value;
  logic [31:0] iv_chunk_size_img;
  logic i_stream_enable;
  logic o_data_valid;
  logic [31:0] ov_data;
  logic [31:0] ov_valid_payload_size;
  logic [15:0] ov_status;
  logic o_chunk_done;

  always #5 clk = ~clk;

  u3v_payload_chunk_gen dut (
    .clk                   (clk),
    .reset                 (reset),
    .i_image_flag          (i_image_flag),
    .i_chunk_flag          (i_chunk_flag),
    .i_data_valid          (i_data_valid),
    .iv_data               (iv_data),
    .i_chunk_mode_active   (i_chunk_mode_active),
    .iv_chunk_en           (iv_chunk_en),
    .iv_chunk_value        (iv_chunk_value),
    .iv_chunk_size_img     (iv_chunk_size_img),
    .i_stream_enable       (i_stream_enable),
    .o_data_valid          (o_data_valid),
    .ov_data               (ov_data),
    .ov_valid_payload_size (ov_valid_payload_size),
    .ov_status             (ov_status),
    .o_chunk_done          (o_chunk_done)
  );

  localparam logic [63:0] V0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] V1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] V2 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] V3 = 64'hDDDD_EEEE_FFFF_0123;

  int errors = 0;
  int checks = 0;

  logic [31:0] words[$];
  int wcyc[$];
  int cyc = 0;
  int ndone = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    if (o_data_valid === 1'b1) begin
      words.push_back(ov_data);
      wcyc.push_back(cyc);
    end
    if (o_chunk_done === 1'b1) begin
      ndone++;
      done_cyc = cyc;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input int base, input int dbase,
                         input logic [31:0] exp[$], input bit exp_done);
    int n;
    n = words.size() - base;
    chk({tag, "_count"}, 32'(n), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (base + i < words.size())
        chk($sformatf("%s_w%0d", tag, i), words[base + i], exp[i]);
    if (exp.size() > 0 && n == exp.size())
      chk({tag, "_b2b"}, 32'(wcyc[base + n - 1] - wcyc[base]), 32'(n - 1));
    chk({tag, "_done"}, 32'(ndone - dbase), exp_done ? 32'd1 : 32'd0);
    if (exp_done && n > 0 && (ndone - dbase) == 1)
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(wcyc[base + n - 1] + 1));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic relatch(input logic m, input logic [3:0] e);
    i_stream_enable = 1'b0;
    tick(2);
    i_chunk_mode_active = m;
    iv_chunk_en = e;
    i_stream_enable = 1'b1;
    tick(3);
  endtask

  task automatic img_burst(input int n, input logic [31:0] sz);
    iv_chunk_size_img = sz;
    i_image_flag = 1'b1;
    for (int i = 0; i < n; i++) begin
      i_data_valid = 1'b1;
      iv_data = 32'h1000 + 32'(i);
      tick(1);
    end
    i_image_flag = 1'b0;
    i_data_valid = 1'b0;
    iv_data = '0;
    tick(3);
  endtask

  initial begin
    logic [31:0] e[$];
    int b, d;

    reset = 1'b1;
    i_image_flag = 0; i_chunk_flag = 0; i_data_valid = 0; iv_data = '0;
    i_chunk_mode_active = 0; iv_chunk_en = '0; iv_chunk_value = '0;
    iv_chunk_size_img = '0; i_stream_enable = 0;
    tick(2);
    chk("rst_valid", 32'(o_data_valid), 32'd0);
    chk("rst_data", ov_data, 32'd0);
    chk("rst_done", 32'(o_chunk_done), 32'd0);
    chk("rst_status", 32'(ov_status), 32'd0);
    chk("rst_payload", ov_valid_payload_size, 32'd0);
    reset = 1'b0;
    tick(2);

    iv_chunk_value = {V3, V2, V1, V0};
    iv_chunk_size_img = 32'h100;

    // Full sequence, entries 0 and 2.
    relatch(1'b1, 4'b0101);
    e.delete();
    e.push_back(32'h1); e.push_back(32'h100);
    e.push_back(V0[31:0]); e.push_back(V0[63:32]); e.push_back(32'd2); e.push_back(32'h8);
    e.push_back(V2[31:0]); e.push_back(V2[63:32]); e.push_back(32'd4); e.push_back(32'h8);
    b = words.size(); d = ndone;
    i_chunk_flag = 1'b1; tick(12); i_chunk_flag = 1'b0; tick(4);
    chk_seq("seq0101", b, d, e, 1'b1);

    // Config changes without a stream-enable rise are ignored.
    i_chunk_mode_active = 1'b0; iv_chunk_en = 4'b0000;
    b = words.size(); d = ndone;
    i_chunk_flag = 1'b1; tick(12); i_chunk_flag = 1'b0; tick(4);
    chk_seq("mode_hold", b, d, e, 1'b1);

    // Mode 0 latched: no chunk output.
    relatch(1'b0, 4'b0101);
    e.delete();
    b = words.size(); d = ndone;
    i_chunk_flag = 1'b1; tick(12); i_chunk_flag = 1'b0; tick(4);
    chk_seq("mode0", b, d, e, 1'b0);

    // Abort after the third word.
    relatch(1'b1, 4'b0101);
    e.delete();
    e.push_back(32'h1); e.push_back(32'h100); e.push_back(V0[31:0]);
    b = words.size(); d = ndone;
    i_chunk_flag = 1'b1; tick(4); i_chunk_flag = 1'b0; tick(6);
    chk_seq("abort", b, d, e, 1'b0);

    // Image word inserted mid-sequence holds the sequencer.
    relatch(1'b1, 4'b0001);
    e.delete();
    e.push_back(32'h1); e.push_back(32'hDEADBEEF); e.push_back(32'h100);
    e.push_back(V0[31:0]); e.push_back(V0[63:32]); e.push_back(32'd2); e.push_back(32'h8);
    b = words.size(); d = ndone;
    i_chunk_flag = 1'b1; tick(2);
    i_image_flag = 1'b1; i_data_valid = 1'b1; iv_data = 32'hDEADBEEF; tick(1);
    i_image_flag = 1'b0; i_data_valid = 1'b0; iv_data = '0;
    tick(8); i_chunk_flag = 1'b0; tick(3);
    chk_seq("img_hold", b, d, e, 1'b1);

    // Registered image forwarding; valid low forces data to zero.
    relatch(1'b1, 4'b0101);
    i_image_flag = 1'b1; i_data_valid = 1'b1; iv_data = 32'hCAFE0001;
    @(posedge clk); @(negedge clk);
    chk("fwd_valid", 32'(o_data_valid), 32'd1);
    chk("fwd_data", ov_data, 32'hCAFE0001);
    i_data_valid = 1'b0; iv_data = 32'h5A5A5A5A;
    @(posedge clk); @(negedge clk);
    chk("fwd_idle_valid", 32'(o_data_valid), 32'd0);
    chk("fwd_idle_data", ov_data, 32'd0);
    i_image_flag = 1'b0; iv_data = '0;
    tick(3);

    // Byte accounting and status.
    img_burst(64, 32'h80);
    chk("over_status", 32'(ov_status), 32'h0000A101);
    chk("over_payload", ov_valid_payload_size, 32'hA8);
    img_burst(32, 32'h80);
    chk("exact_status", 32'(ov_status), 32'h0);
    chk("exact_payload", ov_valid_payload_size, 32'hA8);
    relatch(1'b0, 4'b0101);
    img_burst(16, 32'h80);
    chk("m0_under_status", 32'(ov_status), 32'h0);
    chk("m0_under_payload", ov_valid_payload_size, 32'h40);
    img_burst(64, 32'h80);
    chk("m0_over_status", 32'(ov_status), 32'h0000A101);
    chk("m0_over_payload", ov_valid_payload_size, 32'h80);

    // Reset during the entry phase.
    relatch(1'b1, 4'b0101);
    iv_chunk_size_img = 32'h100;
    i_chunk_flag = 1'b1; tick(5);
    reset = 1'b1; #1;
    chk("rstmid_valid", 32'(o_data_valid), 32'd0);
    chk("rstmid_data", ov_data, 32'd0);
    chk("rstmid_done", 32'(o_chunk_done), 32'd0);
    chk("rstmid_status", 32'(ov_status), 32'd0);
    chk("rstmid_payload", ov_valid_payload_size, 32'd0);
    b = words.size(); d = ndone;
    tick(2); reset = 1'b0; tick(8);
    chk("rstmid_quiet_words", 32'(words.size() - b), 32'd0);
    chk("rstmid_quiet_done", 32'(ndone - d), 32'd0);
    i_chunk_flag = 1'b0; tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
